// File: rtl/pcie_tl_control_fsm_pkg.sv
// Shared transaction-layer definitions: one-hot control states and default widths.
// The referee compares state[3:0] against the same constants.
package pcie_tl_control_fsm_pkg;

    localparam int unsigned THR_W_DEF = 3;
    localparam int unsigned NFIFO_DEF = 8;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } tl_state_e;

endpackage

// File: rtl/pcie_tl_control_fsm.sv
// Transaction-layer control FSM: sequences the referee, latches FIFO thresholds,
// detects the all-FIFOs-idle condition and traps FIFO overflow/underflow errors.
module pcie_tl_control_fsm
    import pcie_tl_control_fsm_pkg::*;
#(
    parameter int unsigned THR_W = THR_W_DEF,
    parameter int unsigned NFIFO = NFIFO_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [THR_W-1:0] umbral_alto_in,
    input  logic [THR_W-1:0] umbral_bajo_in,
    input  logic [NFIFO-1:0] fifo_empty,
    input  logic [NFIFO-1:0] fifo_error,
    output logic [4:0]       state,
    output logic             idle_out,
    output logic [THR_W-1:0] umbral_alto_out,
    output logic [THR_W-1:0] umbral_bajo_out,
    output logic [NFIFO-1:0] error_vec,
    output logic             error_out
);

    tl_state_e        r_state;
    tl_state_e        w_next;
    logic             r_idle;
    logic             r_error;
    logic [THR_W-1:0] r_alto;
    logic [THR_W-1:0] r_bajo;
    logic [NFIFO-1:0] r_error_vec;
    logic             w_any_error;
    logic             w_all_empty;

    assign w_any_error = |fifo_error;
    assign w_all_empty = &fifo_empty;

    // Priority: error > init > empty-based moves; reset is handled in the register.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_RESET: w_next = ST_INIT;
            ST_INIT: begin
                if (w_any_error)  w_next = ST_ERROR;
                else if (init)    w_next = ST_INIT;
                else              w_next = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (w_any_error)      w_next = ST_ERROR;
                else if (init)        w_next = ST_INIT;
                else if (w_all_empty) w_next = ST_IDLE;
                else                  w_next = ST_ACTIVE;
            end
            ST_ERROR: w_next = ST_ERROR;
            default:  w_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RESET;
            r_idle      <= 1'b0;
            r_error     <= 1'b0;
            r_alto      <= '0;
            r_bajo      <= '0;
            r_error_vec <= '0;
        end else begin
            r_state <= w_next;
            r_idle  <= (w_next == ST_IDLE);
            r_error <= (w_next == ST_ERROR);
            if (r_state == ST_INIT) begin
                r_alto <= umbral_alto_in;
                r_bajo <= umbral_bajo_in;
            end
            // Entering ERROR starts a fresh record; staying in ERROR accumulates.
            if (w_next == ST_ERROR) begin
                r_error_vec <= ((r_state == ST_ERROR) ? r_error_vec : '0) | fifo_error;
            end
        end
    end

    assign state           = r_state;
    assign idle_out        = r_idle;
    assign error_out       = r_error;
    assign umbral_alto_out = r_alto;
    assign umbral_bajo_out = r_bajo;
    assign error_vec       = r_error_vec;

endmodule

// File: tb/tb_pcie_tl_control_fsm.sv
// Scoreboard bench for pcie_tl_control_fsm: directed sequences then random traffic,
// checked against a mode-level reference model.
module tb_pcie_tl_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic [2:0] umbral_alto_in = '0;
    logic [2:0] umbral_bajo_in = '0;
    logic [7:0] fifo_empty = '1;
    logic [7:0] fifo_error = '0;
    logic [4:0] state;
    logic       idle_out;
    logic [2:0] umbral_alto_out;
    logic [2:0] umbral_bajo_out;
    logic [7:0] error_vec;
    logic       error_out;

    pcie_tl_control_fsm #(.THR_W(3), .NFIFO(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .umbral_alto_in (umbral_alto_in),
        .umbral_bajo_in (umbral_bajo_in),
        .fifo_empty     (fifo_empty),
        .fifo_error     (fifo_error),
        .state          (state),
        .idle_out       (idle_out),
        .umbral_alto_out(umbral_alto_out),
        .umbral_bajo_out(umbral_bajo_out),
        .error_vec      (error_vec),
        .error_out      (error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] st;
        logic       idle;
        logic       err;
        logic [2:0] alto;
        logic [2:0] bajo;
        logic [7:0] ev;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 0;

    // Reference model: mode 0..4 = reset, init, idle, active, error.
    int         m_mode = 0;
    logic [2:0] m_alto = '0;
    logic [2:0] m_bajo = '0;
    logic [7:0] m_ev   = '0;

    task automatic step(input logic r, input logic i, input logic [2:0] a, input logic [2:0] b,
                        input logic [7:0] emp, input logic [7:0] er);
        exp_t e;
        int   nm;
        @(negedge clk);
        reset = r; init = i; umbral_alto_in = a; umbral_bajo_in = b;
        fifo_empty = emp; fifo_error = er;
        if (r) begin
            nm = 0; m_alto = '0; m_bajo = '0; m_ev = '0;
        end else begin
            if (m_mode == 1) begin m_alto = a; m_bajo = b; end
            if (m_mode == 0)                    nm = 1;
            else if (m_mode == 4)               nm = 4;
            else if (er != 0)                   nm = 4;
            else if (i)                         nm = 1;
            else if (m_mode == 1)               nm = 2;
            else                                nm = (emp == 8'hFF) ? 2 : 3;
            if (nm == 4) m_ev = ((m_mode == 4) ? m_ev : 8'h00) | er;
        end
        m_mode = nm;
        e.st   = 5'(1 << m_mode);
        e.idle = (m_mode == 2);
        e.err  = (m_mode == 4);
        e.alto = m_alto;
        e.bajo = m_bajo;
        e.ev   = m_ev;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Monitor: outputs are presented every cycle; pop and compare after each edge.
    initial begin
        exp_t e;
        while (!(done && q.size() == 0)) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",     8'(state),           8'(e.st));
                chk("idle_out",  8'(idle_out),        8'(e.idle));
                chk("error_out", 8'(error_out),       8'(e.err));
                chk("umbral_alto", 8'(umbral_alto_out), 8'(e.alto));
                chk("umbral_bajo", 8'(umbral_bajo_out), 8'(e.bajo));
                chk("error_vec", error_vec,           e.ev);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] emp, er;
        // Bring-up and threshold load 6/2, then idle.
        repeat (2) step(1, 0, 0, 0, 8'hFF, 8'h00);
        repeat (3) step(0, 1, 6, 2, 8'hFF, 8'h00);
        step(0, 0, 6, 2, 8'hFF, 8'h00);
        // IDLE -> ACTIVE for 4 cycles -> IDLE.
        repeat (4) step(0, 0, 1, 1, 8'hFE, 8'h00);
        step(0, 0, 1, 1, 8'hFF, 8'h00);
        // Error trap from ACTIVE, accumulation, init ignored.
        step(0, 0, 0, 0, 8'hFE, 8'h00);
        step(0, 0, 0, 0, 8'hFE, 8'h20);
        step(0, 1, 0, 0, 8'hFE, 8'h01);
        repeat (2) step(0, 1, 0, 0, 8'hFF, 8'h00);
        // init and error on the same edge in IDLE.
        step(1, 0, 0, 0, 8'hFF, 8'h00);
        step(0, 1, 3, 3, 8'hFF, 8'h00);
        step(0, 0, 3, 3, 8'hFF, 8'h00);
        step(0, 0, 3, 3, 8'hFF, 8'h00);
        step(0, 1, 3, 3, 8'hFF, 8'h80);
        // Reset mid-ACTIVE, then re-init with 5/1.
        step(1, 0, 0, 0, 8'hFF, 8'h00);
        step(0, 1, 6, 2, 8'hFF, 8'h00);
        step(0, 0, 6, 2, 8'hFF, 8'h00);
        step(0, 0, 6, 2, 8'hFD, 8'h00);
        step(1, 0, 6, 2, 8'hFD, 8'h00);
        repeat (2) step(0, 1, 5, 1, 8'hFF, 8'h00);
        step(0, 0, 5, 1, 8'hFF, 8'h00);
        // init from ACTIVE reloads thresholds while held.
        step(0, 0, 0, 0, 8'h7F, 8'h00);
        step(0, 1, 4, 7, 8'h7F, 8'h00);
        step(0, 1, 2, 3, 8'h7F, 8'h00);
        step(0, 0, 2, 3, 8'h7F, 8'h00);
        step(0, 0, 2, 3, 8'hFF, 8'h00);
        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            emp = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            er  = ($urandom_range(0, 24) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            step($urandom_range(0, 29) == 0, $urandom_range(0, 6) == 0,
                 3'($urandom), 3'($urandom), emp, er);
        end
        @(negedge clk);
        done = 1;
    end

endmodule

// File: doc/pcie_tl_control_fsm.md
# pcie_tl_control_fsm

Control state machine for the PCIe transaction layer. It generates the one-hot `state` word that sequences the referee, and latches the FIFO almost-full/almost-empty thresholds. It detects the idle condition across all eight transaction-layer FIFOs and traps FIFO overflow/underflow errors. It sits directly upstream of the referee and the FIFO bank; its outputs are their control inputs.

## Interface
- `THR_W`, default 3: width of each threshold field (FIFO depth 8).
- `NFIFO`, default 8: number of monitored FIFOs. Bits [3:0] are the input FIFOs, bits [7:4] the output FIFOs.
- `clk`  in  1  — single clock; all logic on its rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `init`  in  1  — request (re)initialisation and threshold load.
- `umbral_alto_in`  in  THR_W  — almost-full threshold, sampled in INIT.
- `umbral_bajo_in`  in  THR_W  — almost-empty threshold, sampled in INIT.
- `fifo_empty`  in  NFIFO  — per-FIFO empty flags.
- `fifo_error`  in  NFIFO  — per-FIFO overflow/underflow pulses.
- `state`  out  5  — one-hot, registered. RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000. Bits [3:0] feed the referee.
- `idle_out`  out  1  — registered; high exactly while in IDLE.
- `umbral_alto_out`, `umbral_bajo_out`  out  THR_W  — registered thresholds driven to all FIFOs.
- `error_vec`  out  NFIFO  — sticky record of the FIFOs that raised `fifo_error`.
- `error_out`  out  1  — high exactly while in ERROR.

## Operation
- Transition priority, evaluated every edge: `reset` > any `fifo_error` bit (from INIT/IDLE/ACTIVE) > `init` (from IDLE/ACTIVE) > empty-based transitions.
- RESET: next state is always INIT once `reset` is low.
- INIT:
  - `umbral_*_out` load `umbral_*_in` on every edge while in INIT.
  - Stay in INIT while `init`=1; go to IDLE when `init`=0.
  - FIFOs are not evaluated in INIT.
- IDLE:
  - All `fifo_empty`=1: stay in IDLE.
  - Any `fifo_empty`=0: go to ACTIVE.
- ACTIVE:
  - All `fifo_empty`=1: go to IDLE.
  - Otherwise stay in ACTIVE.
- ERROR:
  - Absorbing; only `reset` exits it. `init` is ignored.
  - `error_vec` keeps ORing in new `fifo_error` bits.
  - `state[3:0]`=0000, so the referee issues no new pops or pushes.
- `error_vec` loads `fifo_error` on the edge that enters ERROR. It is never cleared except by `reset`.
- Thresholds hold their last INIT value in IDLE, ACTIVE and ERROR. There is no arithmetic and no range check on them.
- Reset values: `state`=00001, `idle_out`=0, `umbral_alto_out`=0, `umbral_bajo_out`=0, `error_vec`=0, `error_out`=0.

## Timing
- All outputs are registered. Inputs sampled at edge n are reflected on outputs after edge n.
- `idle_out` and `error_out` change on the same edge as `state`. They are derived from next-state, not from a second register stage.
- Threshold latency: a value present at edge n while in INIT appears on `umbral_*_out` after edge n. The value sampled on the edge that leaves INIT is the last one loaded.
- `reset` asserted mid-ACTIVE or mid-ERROR: `state`=RESET and all outputs take their reset values after the next edge.
- `init` and an error bit on the same edge: ERROR wins.
- In IDLE, a FIFO going non-empty for one cycle still causes IDLE→ACTIVE. ACTIVE→IDLE then follows on the next edge if all FIFOs are empty again.
- Reset exit: reset released at edge n leads to RESET at n, INIT at n+1, and IDLE at n+2 at the earliest (when `init`=0).

## Structure
- Shared transaction-layer package:
  - State encodings RESET/INIT/IDLE/ACTIVE/ERROR as 5-bit localparams.
  - `THR_W` and `NFIFO` defaults.
  - The same state constants are used by the referee's comparisons on `state[3:0]`.
- Single module, no sub-module: one next-state block plus registered outputs.

## Test plan
- Reset then `init`=1 for 3 cycles with alto=6, bajo=2, then `init`=0 and all empty → states RESET, INIT×3, IDLE; `umbral_alto_out`=6, `umbral_bajo_out`=2; `idle_out`=1.
- In IDLE, set `fifo_empty`=8'hFE for 4 cycles, then 8'hFF → ACTIVE for 4 cycles then IDLE; `idle_out` low exactly during ACTIVE.
- In ACTIVE, pulse `fifo_error`=8'h20 for 1 cycle, then 8'h01 → ERROR entered; `error_vec`=8'h21; `state`=10000; `init`=1 ignored.
- Same edge `init`=1 and `fifo_error`=8'h80 in IDLE → ERROR, `error_vec`=8'h80.
- `reset` mid-ACTIVE with thresholds 6/2 → `state`=00001, thresholds 0, `error_vec`=0 after one edge; re-init with alto=5, bajo=1 → outputs 5/1.
- In ACTIVE, `init`=1 → INIT on the next edge; new threshold values load while `init` is held.
